// File: rtl/MemoryBus.sv
// Bus command/result types shared by the platform slave mux and its peripherals.
package MemoryBus;

  typedef struct packed {
    logic [31:0] address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mask_byte;
    logic [31:0] write_data;
  } Cmd;

  typedef struct packed {
    logic [31:0] read_data;
  } Result;

endpackage

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX FIFO plus serializer; RX deserializer built only when
// UART_RX_EN is defined (otherwise rx is ignored and the RX status bits read 0).
module uart_mmio #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  MemoryBus::Cmd    membuscmd,
  output MemoryBus::Result membusres,
  input  logic             rx,
  output logic             tx
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic wr_byte, wr_ctrl, unused_bits;
  assign wr_byte     = membuscmd.mem_write & membuscmd.mask_byte[0];
  assign wr_ctrl     = membuscmd.mem_write & membuscmd.mask_byte[1];
  assign unused_bits = ^{membuscmd, rx};

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   fcnt_q;
  logic          fifo_full, fifo_empty, fifo_pop, push, drop;
  logic          tx_dropped_q;

  assign fifo_full  = (fcnt_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (fcnt_q == '0);
  // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted.
  assign push = wr_byte & (~fifo_full | fifo_pop);
  assign drop = wr_byte & fifo_full & ~fifo_pop;

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wptr_q] <= membuscmd.write_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      fcnt_q       <= '0;
      tx_dropped_q <= 1'b0;
    end else begin
      if (push)     wptr_q <= wptr_q + 1'b1;
      if (fifo_pop) rptr_q <= rptr_q + 1'b1;
      if (push && !fifo_pop)      fcnt_q <= fcnt_q + 1'b1;
      else if (!push && fifo_pop) fcnt_q <= fcnt_q - 1'b1;
      if (drop)                                       tx_dropped_q <= 1'b1;
      else if (wr_ctrl && membuscmd.write_data[12]) tx_dropped_q <= 1'b0;
    end
  end

  // ---------------- TX serializer ----------------
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_mem_q[rptr_q];
          tx_state_d = TX_START;
          tx_d       = 1'b0;
        end
      end
      TX_START: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
        tx_shift_d = tx_shift_q >> 1;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_d       = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      TX_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_mem_q[rptr_q];
          tx_state_d = TX_START;
          tx_d       = 1'b0;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign tx = tx_q;

`ifdef UART_RX_EN
  // ---------------- RX deserializer ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d, rx_data_q;
  logic          rx_s1_q, rx_s2_q, rx_valid_q, rx_overrun_q, rx_ferr_q;
  logic          stop_ok, stop_bad, rx_pop;

  assign rx_pop = membuscmd.mem_read & membuscmd.mask_byte[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      rx_ferr_q    <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      if (stop_ok && (!rx_valid_q || rx_pop)) begin
        rx_data_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
      end else if (rx_pop) begin
        rx_valid_q <= 1'b0;
      end
      if (stop_ok && rx_valid_q && !rx_pop)          rx_overrun_q <= 1'b1;
      else if (wr_ctrl && membuscmd.write_data[9]) rx_overrun_q <= 1'b0;
      if (stop_bad)                                   rx_ferr_q <= 1'b1;
      else if (wr_ctrl && membuscmd.write_data[13]) rx_ferr_q <= 1'b0;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == BIT_HALF) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        stop_ok    = rx_s2_q;
        stop_bad   = ~rx_s2_q;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end
`endif

  always_comb begin
    membusres           = '0;
    membusres.read_data[10]    = fifo_full;
    membusres.read_data[11]    = fifo_empty & (tx_state_q == TX_IDLE);
    membusres.read_data[12]    = tx_dropped_q;
    membusres.read_data[19:16] = 4'(fcnt_q);
`ifdef UART_RX_EN
    membusres.read_data[7:0]   = rx_data_q;
    membusres.read_data[8]     = rx_valid_q;
    membusres.read_data[9]     = rx_overrun_q;
    membusres.read_data[13]    = rx_ferr_q;
`endif
  end

endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped UART peripheral. It is the slave on the UART port of the platform slave bus mux, at word address 'h800, size 1 word.
- Consumes MemoryBus::Cmd and produces MemoryBus::Result.
- TX path: bus writes push bytes into a TX FIFO, and a serializer drains it onto tx as 8N1 frames.
- RX path (optional): deserializes rx into a one-byte holding register with status flags.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit. Minimum 4, must be even.
- FIFO_DEPTH, 4, TX FIFO entries. Allowed values: 2, 4, 8.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- membuscmd  input  MemoryBus::Cmd  bus command (address, mem_read, mem_write, mask_byte[3:0], write_data)
- membusres  output  MemoryBus::Result  bus result (read_data, 32 bits)
- rx  input  1  serial receive line, asynchronous
- tx  output  1  serial transmit line, registered

Behaviour:
- Single clock domain: clk. Synchronous, active-high reset: rst. The address is ignored because the mux has already decoded it.
- Reset values:
  - tx=1
  - FIFO empty
  - all status flags 0
  - TX and RX FSMs in IDLE
  - rx synchronizer flops = 1
- Status word (read_data), combinational from registered state:
  - [7:0] rx_data
  - [8] rx_valid
  - [9] rx_overrun
  - [10] tx_full
  - [11] tx_empty (FIFO empty AND serializer IDLE)
  - [12] tx_dropped
  - [13] rx_frame_err
  - [19:16] tx_count
  - all other bits 0
- Write with mem_write & mask_byte[0]:
  - If the FIFO is not full, write_data[7:0] is pushed at the clock edge.
  - If the FIFO is full, the byte is dropped and tx_dropped is set (sticky).
- Write with mem_write & mask_byte[1] clears sticky flags:
  - write_data[9]=1 clears rx_overrun.
  - write_data[12]=1 clears tx_dropped.
  - write_data[13]=1 clears rx_frame_err.
  - The push and the clear may occur in the same cycle.
- Read with mem_read & mask_byte[0] pops the RX byte: rx_valid clears at the edge. Status is still returned in that same cycle.
- If mem_read and mem_write are both 0, nothing happens.
- TX FSM:
  - States: IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. The FIFO is popped and the byte is latched on that edge.
  - Push at edge N into an idle block: FIFO pop at edge N+1; tx=0 from edge N+1 onward.
  - Each state lasts CLKS_PER_BIT cycles. DATA sends 8 bits, LSB first. STOP drives tx=1.
  - At the end of STOP, if the FIFO is non-empty, go directly to START (no idle gap). Otherwise go to IDLE.
  - One frame lasts 10*CLKS_PER_BIT cycles.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo FIFO_DEPTH, plus a count.
  - Simultaneous push and pop when full: the pop frees a slot first, so the push is accepted and the count is unchanged.
- RX FSM:
  - 2-flop synchronizer on rx.
  - States: IDLE, START, DATA, STOP.
  - IDLE → START on synchronized rx=0.
  - At CLKS_PER_BIT/2, if rx=1 the start is a glitch and the FSM returns to IDLE. Otherwise it goes to DATA.
  - Sample 8 bits, LSB first, every CLKS_PER_BIT cycles, then sample the stop bit.
  - Stop=1, rx_valid=0: load rx_data and set rx_valid.
  - Stop=1, rx_valid=1 and no pop this cycle: keep the old rx_data and set rx_overrun.
  - Stop=1 with a pop in the same cycle: load the new byte, rx_valid stays 1, no overrun.
  - Stop=0: discard the byte and set rx_frame_err.
  - After the stop sample, return to IDLE.
- Reset mid-frame: tx=1 next cycle, FIFO contents lost, the partial RX frame is discarded.

Optional Feature:
- Macro: UART_RX_EN.
- Defined: RX path as described.
- Undefined:
  - rx is unused.
  - Status bits [9:8], [13] and [7:0] read 0.
  - The pop and the rx clear bits have no effect.
  - No RX logic is synthesized.

Test Plan:
1. Reset, CLKS_PER_BIT=4, FIFO_DEPTH=4 → tx=1; read_data=0x00000800.
2. Write 0x55 with mask_byte=0001 at edge 0 → tx=0 over cycles 1–4; then bits 1,0,1,0,1,0,1,0 for 4 cycles each; then stop high for 4 cycles; status bit 11=1 after cycle 40.
3. Six consecutive byte writes into an idle block → first five accepted (one is popped after the first write); sixth dropped; bit 12=1; five back-to-back frames (200 cycles) with no gap between stop and start.
4. Drive an rx frame carrying 0xA3 → rx_valid=1 and read_data[7:0]=0xA3 after the stop sample; read with mask_byte=0001 → bit 8=0 the next cycle.
5. Receive 0x11 then 0x22 with no pop → rx_overrun=1 and rx_data=0x11; write mask_byte=0010, data=0x200 → bit 9=0.
6. Frame with stop bit 0 → bit 13=1 and rx_valid=0; a separate 1-cycle low glitch on rx → no status change.
